// File: rtl/aap_fetch_unit.sv
// rtl/aap_fetch_unit.sv - 16/32-bit instruction fetch with word buffer and branch redirect
// Optional AAP_FETCH_STATS_EN adds a saturating fetch_count of completed transfers.
module aap_fetch_unit #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [15:0]     imem_rdata,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [31:0]     fetchoutput,
    output logic            fetch_is32,
    output logic [PC_W-1:0] fetch_pc,
    output logic            fetch_valid,
    input  logic            decode_ready
`ifdef AAP_FETCH_STATS_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d;
    logic              in_flight_q, in_flight_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       buf_q [BUF_DEPTH];
    logic [15:0]       buf_d [BUF_DEPTH];

    logic [15:0]       head_word;
    logic [15:0]       next_word;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  pop_n;
    logic              transfer;
    logic              push;

    always_comb begin
        head_word   = buf_q[rd_ptr_q];
        next_word   = buf_q[rd_ptr_q + PTR_W'(1)];
        fetch_valid = (count_q != '0) && (!head_word[15] || (count_q >= CNT_W'(2)));
        fetch_is32  = fetch_valid && head_word[15];
        fetchoutput = fetch_valid ? {(fetch_is32 ? next_word : 16'h0000), head_word} : 32'h0;
        fetch_pc    = head_pc_q;
        transfer    = fetch_valid && decode_ready;
        pop_n       = transfer ? (fetch_is32 ? CNT_W'(2) : CNT_W'(1)) : '0;

        // Reserve a slot for every in-flight word so a returning word always fits.
        occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, in_flight_q};
        imem_req    = reset_n && !branch_taken && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
        imem_addr   = pc_q;
        push        = imem_rvalid && (state_q == ST_RUN);

        state_d     = ST_RUN;
        pc_d        = pc_q;
        head_pc_d   = head_pc_q;
        in_flight_d = imem_req;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        buf_d       = buf_q;

        if (branch_taken) begin
            state_d   = in_flight_q ? ST_DRAIN : ST_RUN;
            pc_d      = branch_target;
            head_pc_d = branch_target;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (imem_req) begin
                pc_d = pc_q + PC_W'(1);
            end
            if (push) begin
                buf_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_d  = rd_ptr_q + pop_n[PTR_W-1:0];
            head_pc_d = head_pc_q + PC_W'(pop_n);
            count_d   = count_q + CNT_W'(push) - pop_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            head_pc_q   <= RESET_PC;
            in_flight_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            head_pc_q   <= head_pc_d;
            in_flight_q <= in_flight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
        buf_q <= buf_d;
    end

`ifdef AAP_FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (transfer && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_aap_fetch_unit.sv
// tb/tb_aap_fetch_unit.sv - scoreboard bench for aap_fetch_unit against an instruction-stream model
module tb_aap_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [31:0] fetchoutput;
    logic        fetch_is32;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        decode_ready;
`ifdef AAP_FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    aap_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetchoutput   (fetchoutput),
        .fetch_is32    (fetch_is32),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .decode_ready  (decode_ready)
`ifdef AAP_FETCH_STATS_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] pc;
        logic        is32;
        logic [31:0] data;
    } exp_t;

    logic [15:0] mem [0:65535];
    exp_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          xfers  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Expected instruction sequence when fetching sequentially from start.
    task automatic push_stream(input logic [15:0] start);
        logic [15:0] pc;
        logic [15:0] w;
        exp_t        e;
        pc = start;
        for (int i = 0; i < 512; i++) begin
            w       = mem[pc];
            e.pc    = pc;
            e.is32  = w[15];
            e.data  = w[15] ? {mem[pc + 16'd1], w} : {16'h0000, w};
            exp_q.push_back(e);
            pc      = pc + (w[15] ? 16'd2 : 16'd1);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        branch_taken = 1'b0;
        cyc();
        chk("rst_req",   {63'd0, imem_req},    64'd0);
        chk("rst_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst_out",   {32'd0, fetchoutput}, 64'd0);
        chk("rst_is32",  {63'd0, fetch_is32},  64'd0);
        chk("rst_pc",    {48'd0, fetch_pc},    64'd0);
`ifdef AAP_FETCH_STATS_EN
        chk("rst_count", {32'd0, fetch_count}, 64'd0);
`endif
        exp_q.delete();
        push_stream(16'h0000);
        reset_n = 1'b1;
    endtask

    task automatic branch_to(input logic [15:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
        cyc();
        exp_q.delete();
        push_stream(t);
        branch_taken = 1'b0;
    endtask

    // Instruction memory: fixed one-cycle read latency.
    initial begin
        logic        r;
        logic [15:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        forever begin
            @(negedge clock);
            r = imem_req;
            a = imem_addr;
            @(posedge clock);
            #1;
            imem_rvalid = r;
            imem_rdata  = r ? mem[a] : 16'h0000;
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && fetch_valid && decode_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected: got pc %h required none", fetch_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer", {15'd0, fetch_pc, fetch_is32, fetchoutput}, {15'd0, e.pc, e.is32, e.data});
                end
            end
        end
    end

    initial begin
        logic [48:0] held;
        reset_n       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        decode_ready  = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        cyc();

        // Three 16-bit instructions, back-to-back, with latency check.
        mem[0] = 16'h020A; mem[1] = 16'h0242; mem[2] = 16'h04C2;
        do_reset();
        @(negedge clock);
        chk("t1_first_req",  {47'd0, imem_req, imem_addr}, {47'd0, 1'b1, 16'h0000});
        cyc(); @(negedge clock);
        chk("t1_valid_c1", {63'd0, fetch_valid}, 64'd0);
        for (int c = 2; c <= 4; c++) begin
            cyc(); @(negedge clock);
            chk("t1_valid_b2b", {63'd0, fetch_valid}, 64'd1);
        end
        cyc();

        // 32-bit instruction waits for its second word.
        mem[0] = 16'h8123; mem[1] = 16'h4567;
        do_reset();
        cyc(); cyc(); @(negedge clock);
        chk("t2_half_valid", {63'd0, fetch_valid}, 64'd0);
        cyc(); @(negedge clock);
        chk("t2_out", {15'd0, fetch_valid, fetch_is32, fetchoutput, fetch_pc},
                      {15'd0, 1'b1, 1'b1, 32'h45678123, 16'h0000});
        cyc();

        // Back-pressure fills the buffer and stops requests.
        mem[0] = 16'h1111; mem[1] = 16'h2222;
        decode_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc(); @(negedge clock);
        held = {fetch_valid, fetchoutput, fetch_pc};
        for (int c = 4; c <= 9; c++) begin
            cyc(); @(negedge clock);
        end
        chk("t3_full_noreq", {63'd0, imem_req}, 64'd0);
        chk("t3_stable", {15'd0, fetch_valid, fetchoutput, fetch_pc}, {15'd0, held});
        cyc();
        decode_ready = 1'b1;
        for (int c = 0; c < 6; c++) cyc();

        // Redirect while a request is outstanding.
        branch_to(16'h0040);
        @(negedge clock);
        chk("t4_valid_drop", {63'd0, fetch_valid}, 64'd0);
        chk("t4_req_target", {47'd0, imem_req, imem_addr}, {47'd0, 1'b1, 16'h0040});
        for (int c = 0; c < 8; c++) cyc();

        // Reset in the middle of a randomly stalled stream.
        for (int c = 0; c < 20; c++) begin
            decode_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        decode_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 8; c++) cyc();

        // Randomized traffic with occasional redirects.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                branch_to(16'($urandom));
            end else begin
                decode_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
        end
        decode_ready = 1'b1;

        // 32-bit instruction straddling the address wrap.
        mem[16'hFFFF] = 16'h8ABC; mem[0] = 16'h1234;
        branch_to(16'hFFFF);
        cyc(); cyc(); @(negedge clock);
        chk("t6_wrap_wait", {63'd0, fetch_valid}, 64'd0);
        cyc(); @(negedge clock);
        chk("t6_wrap", {15'd0, fetch_valid, fetch_is32, fetchoutput, fetch_pc},
                       {15'd0, 1'b1, 1'b1, 32'h12348ABC, 16'hFFFF});
        for (int c = 0; c < 10; c++) cyc();

        chk("xfer_volume", {63'd0, (xfers >= 150)}, 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
